// File: rtl/rr_mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
//   N_REQ_DEF / W_DEF : default requester count and beat width
//   MAX_REQ           : upper bound on requester count supported by rr_pick
//   pick_t            : rr_pick result (found flag + winning index)
//   rr_pick()         : rotate-priority search starting just after ptr
package rr_mux_arb_pkg;

   localparam int unsigned N_REQ_DEF = 4;
   localparam int unsigned W_DEF     = 8;
   localparam int unsigned MAX_REQ   = 32;

   typedef struct packed {
      logic       found;
      logic [7:0] idx;
   } pick_t;

   // First set bit of req[n-1:0] searching ptr+1, ptr+2, ... modulo n.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                     input int unsigned        n,
                                     input int unsigned        ptr);
      pick_t       r;
      int unsigned i;
      r = '0;
      for (int unsigned k = 1; k <= MAX_REQ; k++) begin
         if (k <= n) begin
            i = (ptr + k) % n;
            if (!r.found && req[i[4:0]]) begin
               r.found = 1'b1;
               r.idx   = i[7:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between N_REQ producers, the arbiter and one consumer.
//   up_valid/up_last/up_data : producer side, into the arbiter
//   up_ready                 : one-hot grant back to producers
//   down_valid/down_data/down_last/down_id : registered output beat
//   down_ready               : consumer accept
// Modports: slave = arbiter view, master = producer/consumer (bench) view.
interface rr_mux_arbiter_if
   import rr_mux_arb_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned W     = W_DEF
);
   localparam int unsigned ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]   up_valid;
   logic [N_REQ-1:0]   up_last;
   logic [N_REQ*W-1:0] up_data;
   logic [N_REQ-1:0]   up_ready;
   logic               down_valid;
   logic               down_ready;
   logic [W-1:0]       down_data;
   logic               down_last;
   logic [ID_W-1:0]    down_id;

   modport slave (
      input  up_valid, up_last, up_data, down_ready,
      output up_ready, down_valid, down_data, down_last, down_id
   );

   modport master (
      output up_valid, up_last, up_data, down_ready,
      input  up_ready, down_valid, down_data, down_last, down_id
   );

endinterface

// File: rtl/rr_mux_arb_pick.sv
// Combinational rotate-priority encoder.
//   req   : request vector
//   ptr   : index of the last winner; search starts at ptr+1
//   found : some request is set
//   idx   : winning index
module rr_mux_arb_pick
   import rr_mux_arb_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             found,
   output logic [ID_W-1:0]  idx
);

   pick_t pick;

   always_comb begin
      pick  = rr_pick(MAX_REQ'(req), N_REQ, 32'(ptr));
      // Upper index bits are always zero for a valid pick; folding them into
      // found keeps every result bit meaningful.
      found = pick.found && (pick.idx[7:ID_W] == '0);
      idx   = pick.idx[ID_W-1:0];
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered output channel between N_REQ
// valid/ready requesters.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : rr_mux_arbiter_if.slave (up_* from producers, down_* to consumer)
// Optional feature: define RR_MUX_ARB_LOCK_EN to keep a grant locked to one
// requester until it delivers a beat with up_last=1.
module rr_mux_arbiter
   import rr_mux_arb_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned W     = W_DEF
) (
   input logic            clk,
   input logic            rst,
   rr_mux_arbiter_if.slave bus
);

   localparam int unsigned ID_W = $clog2(N_REQ);

   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  win;
   logic             found;
   logic             slot_free;
   logic             accept;
   logic [N_REQ-1:0] req_eff;
   logic [W-1:0]     sel_data;
   logic             sel_last;

`ifdef RR_MUX_ARB_LOCK_EN
   logic            locked;
   logic [ID_W-1:0] lock_id;

   // While locked only the lock owner is visible to the picker.
   always_comb begin
      req_eff = bus.up_valid;
      if (locked) begin
         req_eff = bus.up_valid & (N_REQ'(1) << lock_id);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         locked  <= 1'b0;
         lock_id <= '0;
      end else if (accept) begin
         if (!locked && !sel_last) begin
            locked  <= 1'b1;
            lock_id <= win;
         end else if (locked && sel_last) begin
            locked  <= 1'b0;
         end
      end
   end
`else
   assign req_eff = bus.up_valid;
`endif

   rr_mux_arb_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req   (req_eff),
      .ptr   (ptr),
      .found (found),
      .idx   (win)
   );

   // Output slot can take a new beat when empty or draining this cycle.
   assign slot_free    = !bus.down_valid || bus.down_ready;
   assign accept       = !rst && slot_free && found;
   assign bus.up_ready = accept ? (N_REQ'(1) << win) : '0;

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win == ID_W'(i)) begin
            sel_data = bus.up_data[i*W +: W];
            sel_last = bus.up_last[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.down_valid <= 1'b0;
         bus.down_data  <= '0;
         bus.down_last  <= 1'b0;
         bus.down_id    <= '0;
         ptr            <= ID_W'(N_REQ - 1);
      end else if (slot_free) begin
         if (found) begin
            bus.down_valid <= 1'b1;
            bus.down_data  <= sel_data;
            bus.down_last  <= sel_last;
            bus.down_id    <= win;
            ptr            <= win;
         end else begin
            bus.down_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;
   import rr_mux_arb_pkg::*;

   localparam int unsigned N = 4;
   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } req_beat_t;

   typedef struct {
      int unsigned  id;
      logic [W-1:0] data;
      logic         last;
   } out_beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   rr_mux_arbiter_if #(.N_REQ(N), .W(W)) bus ();

   rr_mux_arbiter #(.N_REQ(N), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   req_beat_t   rq [N][$];
   out_beat_t   sb [$];
   int unsigned mptr;
`ifdef RR_MUX_ARB_LOCK_EN
   logic        mlocked;
   int unsigned mlock_id;
`endif
   logic        cur_ready;
   int          checks = 0;
   int          passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   // Round-robin rule: first valid requester after the last winner, wrapping.
   function automatic int model_winner(input logic [N-1:0] v, input int unsigned last);
      for (int unsigned k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return int'((last + k) % N);
      end
      return -1;
   endfunction

   function automatic void model_reset();
      mptr = N - 1;
`ifdef RR_MUX_ARB_LOCK_EN
      mlocked  = 1'b0;
      mlock_id = 0;
`endif
   endfunction

   task automatic push_beat(input int unsigned i, input logic [W-1:0] d, input logic l);
      req_beat_t b;
      b.data = d;
      b.last = l;
      rq[i].push_back(b);
   endtask

   // One clock: drive at negedge, predict grant at +3, check up_ready.
   task automatic cycle();
      logic [N-1:0] elig;
      logic [N-1:0] exp_ready;
      int           w;
      out_beat_t    ob;
      @(negedge clk);
      for (int unsigned i = 0; i < N; i++) begin
         bus.up_valid[i] = (rq[i].size() != 0);
         if (rq[i].size() != 0) begin
            bus.up_data[i*W +: W] = rq[i][0].data;
            bus.up_last[i]        = rq[i][0].last;
         end else begin
            bus.up_data[i*W +: W] = W'($urandom);
            bus.up_last[i]        = 1'($urandom);
         end
      end
      bus.down_ready = cur_ready;
      #3;
      exp_ready = '0;
      if (sb.size() == 0) begin
         elig = bus.up_valid;
`ifdef RR_MUX_ARB_LOCK_EN
         if (mlocked) elig = elig & (N'(1) << mlock_id);
`endif
         w = model_winner(elig, mptr);
         if (w >= 0) begin
            exp_ready[w] = 1'b1;
            ob.id   = w;
            ob.data = rq[w][0].data;
            ob.last = rq[w][0].last;
            sb.push_back(ob);
            mptr = w;
`ifdef RR_MUX_ARB_LOCK_EN
            if (!mlocked && !ob.last) begin
               mlocked  = 1'b1;
               mlock_id = w;
            end else if (mlocked && ob.last) begin
               mlocked = 1'b0;
            end
`endif
         end
      end
      chk("up_ready", 32'(bus.up_ready), 32'(exp_ready));
      for (int unsigned i = 0; i < N; i++) begin
         if (bus.up_valid[i] && bus.up_ready[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      end
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) cycle();
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.down_ready = 1'b0;
      #1;
      chk("pre_rst_valid", 32'(bus.down_valid), 32'(sb.size() != 0));
      #1;
      rst = 1'b1;
      #1;
      chk("rst_down_valid", 32'(bus.down_valid), 32'd0);
      chk("rst_up_ready", 32'(bus.up_ready), 32'd0);
      sb.delete();
      model_reset();
      bus.up_valid = '0;
      @(negedge clk);
      #2;
      rst = 1'b0;
   endtask

   // Monitor: compares whatever the output register presents against the scoreboard.
   initial begin
      out_beat_t b;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            chk("down_valid", 32'(bus.down_valid), 32'(sb.size() != 0));
            if (sb.size() != 0 && bus.down_ready) begin
               b = sb.pop_front();
               chk("down_id", 32'(bus.down_id), b.id);
               chk("down_data", 32'(bus.down_data), 32'(b.data));
               chk("down_last", 32'(bus.down_last), 32'(b.last));
            end
         end
      end
   end

   initial begin
      model_reset();
      bus.up_valid   = '0;
      bus.up_last    = '0;
      bus.up_data    = '0;
      bus.down_ready = 1'b0;
      cur_ready      = 1'b1;
      #2;
      bus.up_valid = '1;
      #1;
      chk("reset_down_valid", 32'(bus.down_valid), 32'd0);
      chk("reset_down_data", 32'(bus.down_data), 32'd0);
      chk("reset_down_id", 32'(bus.down_id), 32'd0);
      chk("reset_down_last", 32'(bus.down_last), 32'd0);
      chk("reset_up_ready", 32'(bus.up_ready), 32'd0);
      bus.up_valid = '0;
      @(negedge clk);
      #2;
      rst = 1'b0;

      // All requesters busy, consumer always ready: ids 0,1,2,3,0,...
      for (int unsigned i = 0; i < N; i++)
         for (int k = 0; k < 4; k++) push_beat(i, W'(8'h10 * (i + 1) + k), 1'b1);
      run(20);

      // Lone requester 2 is served every cycle.
      for (int k = 0; k < 8; k++) push_beat(2, 8'hA5, 1'b1);
      run(10);

      // Backpressure: output holds 8'h11 while consumer stalls.
      push_beat(0, 8'h11, 1'b1);
      cur_ready = 1'b0;
      run(1);
      for (int k = 0; k < 3; k++) push_beat(1, W'(8'h20 + k), 1'b1);
      for (int s = 0; s < 5; s++) begin
         cycle();
         chk("stall_data", 32'(bus.down_data), 32'h11);
      end
      cur_ready = 1'b1;
      run(6);

      // Requesters 1 and 3 alternate, after 1 was the last winner.
      push_beat(1, 8'h31, 1'b1);
      run(3);
      for (int k = 0; k < 5; k++) begin
         push_beat(1, W'(8'h40 + k), 1'b1);
         push_beat(3, W'(8'h50 + k), 1'b1);
      end
      run(12);

      // Packet from requester 0 competing with requester 1.
      push_beat(0, 8'h60, 1'b0);
      push_beat(0, 8'h61, 1'b0);
      push_beat(0, 8'h62, 1'b1);
      for (int k = 0; k < 3; k++) push_beat(1, W'(8'h70 + k), 1'b1);
      run(10);

      // Reset while a beat is pending; first grant afterwards goes to 0.
      for (int unsigned i = 0; i < N; i++)
         for (int k = 0; k < 2; k++) push_beat(i, W'(8'h80 + 8'h10 * i + k), 1'b1);
      cur_ready = 1'b0;
      run(2);
      do_reset();
      cur_ready = 1'b1;
      run(12);

      // Randomized traffic with random backpressure and packet ends.
      for (int c = 0; c < 400; c++) begin
         for (int unsigned i = 0; i < N; i++)
            if (rq[i].size() == 0 && $urandom_range(0, 1) == 1)
               push_beat(i, W'($urandom), ($urandom_range(0, 3) == 0));
         cur_ready = ($urandom_range(0, 3) != 0);
         cycle();
         if (c == 200) do_reset();
      end

      // Drain: let every outstanding packet complete.
      cur_ready = 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
         if (rq[i].size() != 0) push_beat(i, W'($urandom), 1'b1);
      end
      run(40);
      chk("drain_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
